// File: rtl/dlx_data_ram_if.sv
// rtl/dlx_data_ram_if.sv - DLX data-memory bus between core (master) and RAM (slave)
interface dlx_data_ram_if;
    logic [31:0] d_address;
    logic [31:0] d_data_write;
    logic        d_write_enable;
    logic [31:0] d_data_read;
    logic        d_data_valid;

    modport master (
        output d_address, d_data_write, d_write_enable,
        input  d_data_read, d_data_valid
    );

    modport slave (
        input  d_address, d_data_write, d_write_enable,
        output d_data_read, d_data_valid
    );
endinterface

// File: rtl/dlx_data_ram.sv
// rtl/dlx_data_ram.sv - word RAM responder with programmable read wait states and write forwarding
module dlx_data_ram #(
    parameter int ADDR_WIDTH = 10,
    parameter int LATENCY    = 2
) (
    input  logic           clk,
    input  logic           reset_n,
    dlx_data_ram_if.slave  bus
);
    typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_VALID} state_t;

    localparam logic [3:0] LAT = 4'(LATENCY);

    logic [31:0] mem [0:(1 << ADDR_WIDTH) - 1];

    state_t          state, state_next;
    logic [3:0]      cnt, cnt_next;
    logic [31:2]     a_q, a_next;
    logic [31:0]     read_q, read_next;
    logic            valid_q, valid_next;

    logic                  restart;
    logic                  wr_in_range;
    logic                  a_in_range;
    logic                  wr_hit;
    logic [ADDR_WIDTH-1:0] wr_idx;
    logic [ADDR_WIDTH-1:0] a_idx;
    logic                  unused_bits;

    assign unused_bits = ^bus.d_address[1:0];

    assign wr_in_range = (bus.d_address[31:ADDR_WIDTH+2] == '0);
    assign wr_idx      = bus.d_address[ADDR_WIDTH+1:2];
    assign a_in_range  = (a_q[31:ADDR_WIDTH+2] == '0);
    assign a_idx       = a_q[ADDR_WIDTH+1:2];
    assign restart     = (state == ST_IDLE) || (bus.d_address[31:2] != a_q);
    // Without a restart the presented word equals a_q, so any write hits the sampled word.
    assign wr_hit      = bus.d_write_enable && wr_in_range;

    // Storage is deliberately not reset so contents survive reset_n.
    always_ff @(posedge clk) begin
        if (bus.d_write_enable && wr_in_range) begin
            mem[wr_idx] <= bus.d_data_write;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= ST_IDLE;
            cnt     <= 4'd0;
            a_q     <= '0;
            read_q  <= 32'h0;
            valid_q <= 1'b0;
        end else begin
            state   <= state_next;
            cnt     <= cnt_next;
            a_q     <= a_next;
            read_q  <= read_next;
            valid_q <= valid_next;
        end
    end

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        a_next     = a_q;
        if (restart) begin
            a_next     = bus.d_address[31:2];
            cnt_next   = LAT;
            state_next = ST_WAIT;
        end else begin
            case (state)
                ST_WAIT: begin
                    if (cnt == 4'd1) state_next = ST_VALID;
                    else             cnt_next   = cnt - 4'd1;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        read_next  = read_q;
        valid_next = valid_q;
        if (restart) begin
            valid_next = 1'b0;
        end else if (state == ST_WAIT && cnt == 4'd1) begin
            valid_next = 1'b1;
            if (!a_in_range) read_next = 32'h0;
            else if (wr_hit) read_next = bus.d_data_write;
            else             read_next = mem[a_idx];
        end else if (state == ST_VALID && wr_hit) begin
            read_next = bus.d_data_write;
        end
    end

    assign bus.d_data_read  = read_q;
    assign bus.d_data_valid = valid_q;
endmodule

// File: tb/tb_dlx_data_ram.sv
// tb/tb_dlx_data_ram.sv - directed and random checks of dlx_data_ram against a stability-count model
module tb_dlx_data_ram;
    localparam int AW  = 10;
    localparam int LAT = 2;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    dlx_data_ram_if bus();

    dlx_data_ram #(.ADDR_WIDTH(AW), .LATENCY(LAT)) dut (
        .clk(clk),
        .reset_n(reset_n),
        .bus(bus)
    );

    int tests = 0;
    int fails = 0;

    // Model: RAM image plus how many edges the current word address has been held.
    logic [31:0] mm [0:(1<<AW)-1];
    logic [29:0] cur_word;
    bit          idle = 1'b1;
    int          stable = 0;

    function automatic bit in_range(input logic [31:0] a);
        return a[31:AW+2] == '0;
    endfunction

    function automatic logic [31:0] model_read();
        logic [31:0] a;
        a = {cur_word, 2'b00};
        if (!in_range(a)) return 32'h0;
        return mm[a[AW+1:2]];
    endfunction

    task automatic check_outputs(input string tag);
        bit ev;
        logic [31:0] ed;
        ev = (stable >= LAT) && !idle;
        tests++;
        assert (bus.d_data_valid === ev) else begin
            fails++;
            $error("FAIL %s valid observed=%0b expected=%0b", tag, bus.d_data_valid, ev);
        end
        if (ev) begin
            ed = model_read();
            tests++;
            assert (bus.d_data_read === ed) else begin
                fails++;
                $error("FAIL %s data observed=%08h expected=%08h", tag, bus.d_data_read, ed);
            end
        end
    endtask

    task automatic cycle(input logic [31:0] addr, input logic [31:0] wdata, input bit we,
                         input bit do_check, input string tag);
        bus.d_address      = addr;
        bus.d_data_write   = wdata;
        bus.d_write_enable = we;
        @(posedge clk);
        if (we && in_range(addr)) mm[addr[AW+1:2]] = wdata;
        if (idle || addr[31:2] != cur_word) begin
            idle     = 1'b0;
            cur_word = addr[31:2];
            stable   = 0;
        end else begin
            stable++;
        end
        #1;
        if (do_check) check_outputs(tag);
    endtask

    task automatic do_reset();
        #2;
        reset_n = 1'b0;
        bus.d_write_enable = 1'b0;
        #1;
        tests++;
        assert (bus.d_data_valid === 1'b0) else begin
            fails++;
            $error("FAIL reset_valid observed=%0b expected=0", bus.d_data_valid);
        end
        tests++;
        assert (bus.d_data_read === 32'h0) else begin
            fails++;
            $error("FAIL reset_data observed=%08h expected=00000000", bus.d_data_read);
        end
        idle   = 1'b1;
        stable = 0;
        repeat (2) @(posedge clk);
        #3;
        reset_n = 1'b1;
    endtask

    initial begin
        logic [31:0] a, d;
        int hold;
        bus.d_address      = 32'h0;
        bus.d_data_write   = 32'h0;
        bus.d_write_enable = 1'b0;
        repeat (2) @(posedge clk);
        #3;
        reset_n = 1'b1;

        for (int i = 0; i < (1 << AW); i++)
            cycle(32'(i) << 2, $urandom, 1'b1, 1'b0, "fill");

        do_reset();
        for (int i = 0; i < 4; i++) cycle(32'h10, 32'h0, 1'b0, 1'b1, "first_read");

        cycle(32'h40, 32'hDEADBEEF, 1'b1, 1'b1, "wr_deadbeef");
        cycle(32'h40, 32'h0, 1'b0, 1'b1, "rd_deadbeef0");
        cycle(32'h40, 32'h0, 1'b0, 1'b1, "rd_deadbeef1");
        tests++;
        assert (bus.d_data_read === 32'hDEADBEEF) else begin
            fails++;
            $error("FAIL deadbeef_const observed=%08h expected=deadbeef", bus.d_data_read);
        end

        for (int i = 0; i < 3; i++) cycle(32'h44, 32'h0, 1'b0, 1'b1, "addr_change");
        cycle(32'h46, 32'h0, 1'b0, 1'b1, "bit1_toggle");
        cycle(32'h44, 32'h0, 1'b0, 1'b1, "bit1_back");

        for (int i = 0; i < 3; i++) cycle(32'h40, 32'h0, 1'b0, 1'b1, "back_to_40");
        cycle(32'h40, 32'h12345678, 1'b1, 1'b1, "valid_fwd");
        tests++;
        assert (bus.d_data_read === 32'h12345678 && bus.d_data_valid === 1'b1) else begin
            fails++;
            $error("FAIL fwd_const observed=%08h/%0b expected=12345678/1",
                   bus.d_data_read, bus.d_data_valid);
        end

        cycle(32'h0001_0000, 32'hFFFFFFFF, 1'b1, 1'b1, "oor_write");
        for (int i = 0; i < 3; i++) cycle(32'h0001_0000, 32'h0, 1'b0, 1'b1, "oor_read");
        for (int i = 0; i < 3; i++) cycle(32'h0, 32'h0, 1'b0, 1'b1, "mem0_intact");

        cycle(32'h80, 32'hA5A5_0001, 1'b1, 1'b1, "wr_80");
        cycle(32'h84, 32'h0, 1'b0, 1'b1, "to_84");
        do_reset();
        for (int i = 0; i < 4; i++) cycle(32'h80, 32'h0, 1'b0, 1'b1, "post_reset_read");

        cycle(32'h90, 32'h0, 1'b0, 1'b1, "wait_wr0");
        cycle(32'h90, 32'hCAFE_F00D, 1'b1, 1'b1, "wait_wr1");
        cycle(32'h90, 32'h0, 1'b0, 1'b1, "wait_wr2");

        for (int t = 0; t < 300; t++) begin
            case ($urandom_range(0, 4))
                0: a = 32'h40;
                1: a = 32'h44;
                2: a = 32'h0001_0000 | ($urandom_range(0, 255) << 2);
                default: a = $urandom_range(0, (1 << AW) - 1) << 2;
            endcase
            hold = $urandom_range(1, 5);
            for (int h = 0; h < hold; h++) begin
                a[1:0] = 2'($urandom_range(0, 3));
                d = $urandom;
                cycle(a, d, ($urandom_range(0, 3) == 0), 1'b1, "random");
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
